mdu_ctrl: RTL

- Multiply/divide unit controller for the pipelined MIPS core.
- Accepts mult/div/mthi/mtlo operations issued from the E stage and sequences a fixed-latency multi-cycle operation.
- Holds the architectural HI/LO registers.
- Generates m_stall, which freezes the D-stage pipeline register while an MDU-dependent instruction waits in D.

---
 rtl/mdu_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller for the pipelined MIPS core.
// Sequences fixed-latency MULT/MULTU/DIV/DIVU operations, holds the
// architectural HI/LO registers and raises the D-stage stall request.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no operation in flight; accepts MDU issue and MTHI/MTLO writes
// S_BUSY | counter running down; HI/LO written on the terminal-count edge
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        m_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic issue_mdu;
    logic issue_mthi;
    logic issue_mtlo;

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_abs;
    logic [31:0]        b_abs;
    logic [31:0]        div_num;
    logic [31:0]        div_den;
    logic [31:0]        q_raw;
    logic [31:0]        r_raw;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_we;

    // Issue decode: md_op 0..3 start a timed operation, 4/5 are direct writes,
    // 6/7 fall through every decode and do nothing.
    assign issue_mdu  = start & ~md_op[2];
    assign issue_mthi = start & (md_op == 3'd4);
    assign issue_mtlo = start & (md_op == 3'd5);

    // Result datapath from the operands latched at issue. Signed division runs
    // on magnitudes and fixes signs afterwards so one unsigned divider serves
    // both DIV and DIVU; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        a_sx    = {{32{a_q[31]}}, a_q};
        b_sx    = {{32{b_q[31]}}, b_q};
        prod_s  = a_sx * b_sx;
        prod_u  = {32'd0, a_q} * {32'd0, b_q};

        a_abs   = a_q[31] ? (32'd0 - a_q) : a_q;
        b_abs   = b_q[31] ? (32'd0 - b_q) : b_q;
        div_num = (op_q == OP_DIV) ? a_abs : a_q;
        div_den = (op_q == OP_DIV) ? b_abs : b_q;
        // Keep the divider free of a zero divisor; the result is discarded then.
        if (div_den == 32'd0) begin
            div_den = 32'd1;
        end
        q_raw   = div_num / div_den;
        r_raw   = div_num % div_den;

        res_hi  = hi_q;
        res_lo  = lo_q;
        res_we  = 1'b0;
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_we = 1'b1;
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_we = 1'b1;
            end
            OP_DIV: begin
                res_lo = (a_q[31] ^ b_q[31]) ? (32'd0 - q_raw) : q_raw;
                res_hi = a_q[31] ? (32'd0 - r_raw) : r_raw;
                res_we = (b_q != 32'd0);
            end
            OP_DIVU: begin
                res_lo = q_raw;
                res_hi = r_raw;
                res_we = (b_q != 32'd0);
            end
            default: begin
                res_we = 1'b0;
            end
        endcase
    end

    // Next-state, counter, operand latch and HI/LO update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (issue_mdu) begin
                    state_d = S_BUSY;
                    op_d    = md_op[1:0];
                    a_d     = rs_val;
                    b_d     = rt_val;
                    cnt_d   = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end else if (issue_mthi) begin
                    hi_d = rs_val;
                end else if (issue_mtlo) begin
                    lo_d = rs_val;
                end
            end
            S_BUSY: begin
                // A start seen here is deliberately dropped.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (res_we) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // The stall covers the issue cycle combinationally and every busy cycle;
    // it drops in the cycle the new HI/LO become visible.
    assign busy    = (state_q == S_BUSY);
    assign m_stall = d_is_md & (busy | issue_mdu);
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
